// File: rtl/kernel_pr_write_back.sv
// PageRank write-back stage: drains rank words from a value FIFO into bursts
// on a write-master port, one job per start token, one burst in flight.
//
// state  | meaning
// IDLE   | waiting for a start token; latches base address and word count
// REQ    | presenting a burst request, fields held until accepted
// DATA   | streaming beats; each beat is a value FIFO pop
// RESP   | waiting for the burst write response, then advancing the address
// DONE   | one-cycle completion pulse
module kernel_pr_write_back #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_empty_n,
  output logic                  start_read,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_vertices,
  input  logic                  val_empty_n,
  output logic                  val_read,
  input  logic [DATA_WIDTH-1:0] val_dout,
  output logic                  wr_req_valid,
  input  logic                  wr_req_ready,
  output logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic [7:0]            wr_req_len,
  output logic                  wr_data_valid,
  input  logic                  wr_data_ready,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_last,
  input  logic                  wr_resp_valid,
  output logic                  wr_resp_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_RESP, S_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0]  BURST_MAX      = CNT_WIDTH'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] BYTES_PER_BEAT = ADDR_WIDTH'(DATA_WIDTH / 8);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  remain_q, remain_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  burst_q, burst_d;
  logic [CNT_WIDTH-1:0]  beats_c;
  logic                  xfer_c;

  assign beats_c = (remain_q < BURST_MAX) ? remain_q : BURST_MAX;
  assign wr_data = val_dout;
  assign busy    = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      beat_cnt_q <= '0;
      burst_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      beat_cnt_q <= beat_cnt_d;
      burst_q    <= burst_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remain_d      = remain_q;
    beat_cnt_d    = beat_cnt_q;
    burst_d       = burst_q;
    xfer_c        = 1'b0;
    start_read    = 1'b0;
    val_read      = 1'b0;
    wr_req_valid  = 1'b0;
    wr_req_addr   = '0;
    wr_req_len    = '0;
    wr_data_valid = 1'b0;
    wr_data_last  = 1'b0;
    wr_resp_ready = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        start_read = start_empty_n;
        if (start_empty_n) begin
          addr_d   = base_addr;
          remain_d = num_vertices;
          state_d  = (num_vertices == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        wr_req_valid = 1'b1;
        wr_req_addr  = addr_q;
        wr_req_len   = 8'(beats_c - CNT_WIDTH'(1));
        if (wr_req_ready) begin
          burst_d    = beats_c;
          beat_cnt_d = beats_c;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        // a beat is only offered when a value is present, so no bubble beats
        wr_data_valid = val_empty_n;
        wr_data_last  = (beat_cnt_q == CNT_WIDTH'(1));
        xfer_c        = val_empty_n & wr_data_ready;
        val_read      = xfer_c;
        if (xfer_c) begin
          beat_cnt_d = beat_cnt_q - CNT_WIDTH'(1);
          remain_d   = remain_q - CNT_WIDTH'(1);
          if (beat_cnt_q == CNT_WIDTH'(1)) state_d = S_RESP;
        end
      end
      S_RESP: begin
        wr_resp_ready = 1'b1;
        if (wr_resp_valid) begin
          addr_d  = addr_q + ADDR_WIDTH'(burst_q) * BYTES_PER_BEAT;
          state_d = (remain_q != '0) ? S_REQ : S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_kernel_pr_write_back.sv
// Scoreboard bench for kernel_pr_write_back: FIFO/memory models around the DUT,
// expected requests, beats and job completions queued when a job is pushed.
module tb_kernel_pr_write_back;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BL = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_empty_n = 1'b0;
  logic          start_read;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_vertices = '0;
  logic          val_empty_n = 1'b0;
  logic          val_read;
  logic [DW-1:0] val_dout = '0;
  logic          wr_req_valid;
  logic          wr_req_ready = 1'b0;
  logic [AW-1:0] wr_req_addr;
  logic [7:0]    wr_req_len;
  logic          wr_data_valid;
  logic          wr_data_ready = 1'b0;
  logic [DW-1:0] wr_data;
  logic          wr_data_last;
  logic          wr_resp_valid = 1'b0;
  logic          wr_resp_ready;
  logic          busy;
  logic          done;

  kernel_pr_write_back #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .start_empty_n(start_empty_n), .start_read(start_read),
    .base_addr(base_addr), .num_vertices(num_vertices),
    .val_empty_n(val_empty_n), .val_read(val_read), .val_dout(val_dout),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .wr_data(wr_data), .wr_data_last(wr_data_last),
    .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [63:0] tok_q[$];
  logic [31:0] val_q[$];
  logic [39:0] exp_req[$];
  logic [32:0] exp_beat[$];
  int          exp_bursts[$];
  int          exp_n[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0, beats_seen = 0, resps_job = 0, pops_job = 0;
  int outstanding = 0, pop_cyc = 0;
  bit bp = 0, gap = 0, resp_en = 1, resp_pending = 0;
  bit pop_tok = 0, pop_val = 0, resp_hs = 0, resp_set = 0;
  bit prev_req_wait = 0, prev_done = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic drive_inputs();
    start_empty_n = (tok_q.size() != 0);
    {base_addr, num_vertices} = (tok_q.size() != 0) ? tok_q[0] : 64'd0;
    val_empty_n   = (val_q.size() != 0) && !gap;
    val_dout      = (val_q.size() != 0) ? val_q[0] : '0;
    wr_resp_valid = resp_pending && resp_en;
  endtask

  task automatic push_job(input logic [31:0] base, input int n, input int first);
    logic [31:0] addr;
    int remain, b, k, bursts;
    tok_q.push_back({base, 32'(n)});
    for (int i = 0; i < n; i++) val_q.push_back(32'(first + i));
    addr = base; remain = n; k = 0; bursts = 0;
    while (remain > 0) begin
      b = (remain < BL) ? remain : BL;
      exp_req.push_back({addr, 8'(b - 1)});
      for (int j = 0; j < b; j++) exp_beat.push_back({(j == b - 1), 32'(first + k + j)});
      k += b; remain -= b; addr += 32'(b * 4); bursts++;
    end
    exp_bursts.push_back(bursts);
    exp_n.push_back(n);
    drive_inputs();
  endtask

  task automatic monitor();
    bit beat_hs;
    int b, n;
    pop_tok = 0; pop_val = 0; resp_hs = 0; resp_set = 0;
    if (reset) begin
      prev_req_wait = 0; prev_done = 0;
      return;
    end
    pop_tok = start_read && start_empty_n;
    pop_val = val_read;
    beat_hs = wr_data_valid && wr_data_ready;
    if (beat_hs || val_read) chk("beat_is_pop", 64'(val_read), 64'(beat_hs));
    if (pop_tok) begin
      chk("pop_overlap", 64'(outstanding), 64'd0);
      outstanding++; pop_cyc = cyc; pops_job = 0; resps_job = 0;
    end
    if (prev_req_wait) chk("req_hold", 64'(wr_req_valid), 64'd1);
    if (wr_req_valid) begin
      if (exp_req.size() == 0) chk("req_extra", 64'd1, 64'd0);
      else begin
        chk("req_fields", 64'({wr_req_addr, wr_req_len}), 64'(exp_req[0]));
        if (wr_req_ready) void'(exp_req.pop_front());
      end
    end
    prev_req_wait = wr_req_valid && !wr_req_ready;
    if (beat_hs) begin
      if (exp_beat.size() == 0) chk("beat_extra", 64'd1, 64'd0);
      else chk("beat", 64'({wr_data_last, wr_data}), 64'(exp_beat.pop_front()));
      beats_seen++; pops_job++;
      if (wr_data_last) resp_set = 1;
    end
    resp_hs = wr_resp_valid && wr_resp_ready;
    if (resp_hs) resps_job++;
    if (prev_done) chk("busy_after_done", 64'(busy), 64'd0);
    if (done) begin
      if (exp_bursts.size() == 0) chk("done_extra", 64'd1, 64'd0);
      else begin
        b = exp_bursts.pop_front();
        n = exp_n.pop_front();
        chk("done_bursts", 64'(resps_job), 64'(b));
        chk("done_pops", 64'(pops_job), 64'(n));
        chk("done_busy", 64'(busy), 64'd1);
        if (n == 0) chk("zero_latency", 64'((cyc - pop_cyc) <= 2), 64'd1);
      end
      outstanding--; done_cnt++;
    end
    prev_done = done;
  endtask

  task automatic apply();
    if (pop_tok && tok_q.size() != 0) void'(tok_q.pop_front());
    if (pop_val && val_q.size() != 0) void'(val_q.pop_front());
    if (resp_hs) resp_pending = 0;
    if (resp_set) resp_pending = 1;
    pop_tok = 0; pop_val = 0; resp_hs = 0; resp_set = 0;
    gap           = bp && ($urandom_range(0, 9) < 3);
    wr_req_ready  = !bp || ($urandom_range(0, 9) >= 3);
    wr_data_ready = !bp || ($urandom_range(0, 9) >= 3);
    resp_en       = !bp || ($urandom_range(0, 9) >= 3);
    drive_inputs();
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    apply();
  endtask

  task automatic wait_done(input string tag, input int target, input int max_cyc);
    int k = 0;
    while (done_cnt < target && k < max_cyc) begin
      tick();
      k++;
    end
    chk(tag, 64'(done_cnt), 64'(target));
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, 64'({start_read, val_read, wr_req_valid, wr_data_valid, wr_data_last,
                  wr_resp_ready, busy, done, wr_req_addr, wr_req_len}), 64'd0);
  endtask

  initial begin
    int b0, k;
    reset = 1'b1;
    repeat (3) tick();
    chk_quiet("reset_outputs");
    reset = 1'b0;

    push_job(32'h1000, 5, 1);
    wait_done("job_short", 1, 200);
    chk("short_drain", 64'(exp_req.size() + exp_beat.size() + val_q.size()), 64'd0);

    push_job(32'h2000, 40, 100);
    wait_done("job_multi", 2, 500);

    push_job(32'h3000, 0, 0);
    wait_done("job_zero", 3, 20);

    bp = 1;
    push_job(32'h4000, 33, 200);
    wait_done("job_backpressure", 4, 3000);
    bp = 0;
    chk("bp_drain", 64'(exp_req.size() + exp_beat.size() + val_q.size()), 64'd0);

    push_job(32'h0, 3, 300);
    push_job(32'h100, 2, 400);
    wait_done("job_b2b", 6, 300);

    push_job(32'h5000, 5, 500);
    b0 = beats_seen; k = 0;
    while (beats_seen < b0 + 2 && k < 100) begin
      tick();
      k++;
    end
    chk("reset_reach_beat2", 64'(beats_seen - b0), 64'd2);
    reset = 1'b1;
    tok_q.delete(); val_q.delete(); exp_req.delete(); exp_beat.delete();
    exp_bursts.delete(); exp_n.delete();
    resp_pending = 0; outstanding = 0;
    drive_inputs();
    tick();
    chk_quiet("midjob_reset_outputs");
    reset = 1'b0;
    b0 = beats_seen;
    repeat (3) tick();
    chk("no_beats_after_reset", 64'(beats_seen - b0), 64'd0);
    push_job(32'h6000, 1, 600);
    wait_done("job_after_reset", 7, 100);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kernel_pr_write_back.md
Name: kernel_pr_write_back

Overview:
- Dataflow write-back stage of the PageRank kernel. Sits directly downstream of the 1-bit start-token FIFO feeding write_back.
- On each start token it drains `num_vertices` rank words from an upstream value FIFO and packs them into bursts on a simple memory write-master interface.
- After all write responses are back it pulses `done`.
- Handles exactly one job per start token, one burst in flight at a time.

Parameters:
- DATA_WIDTH, 32, width of one rank word and one write beat.
- ADDR_WIDTH, 32, byte-address width.
- BURST_LEN, 16, maximum beats per burst (1..256).
- CNT_WIDTH, 32, width of the vertex count and beat counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start_empty_n  in  1  start FIFO holds a token.
- start_read  out  1  pops one start token.
- base_addr  in  ADDR_WIDTH  byte address of word 0; sampled on token pop.
- num_vertices  in  CNT_WIDTH  words to write; sampled on token pop.
- val_empty_n  in  1  value FIFO non-empty.
- val_read  out  1  pops one value.
- val_dout  in  DATA_WIDTH  value FIFO head.
- wr_req_valid  out  1  burst request valid.
- wr_req_ready  in  1  request accepted.
- wr_req_addr  out  ADDR_WIDTH  burst start byte address.
- wr_req_len  out  8  beats minus one.
- wr_data_valid  out  1  beat valid.
- wr_data_ready  in  1  beat accepted.
- wr_data  out  DATA_WIDTH  beat data (= val_dout).
- wr_data_last  out  1  final beat of the burst.
- wr_resp_valid  in  1  burst write response.
- wr_resp_ready  out  1  response accepted.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job completion.

Behaviour:
- Reset: state IDLE; all outputs 0; address register and counters cleared. Reset mid-job abandons the job; no further pops, requests or beats occur.
- FSM states: IDLE, REQ, DATA, RESP, DONE.
- IDLE:
  - `start_read = start_empty_n`.
  - On a pop, latch `base_addr` into addr_r and `num_vertices` into remain_r.
  - If remain_r would be 0, go to DONE; otherwise go to REQ. `busy` = 1 from the next cycle.
- REQ:
  - beats = min(BURST_LEN, remain_r).
  - `wr_req_valid` = 1, `wr_req_addr` = addr_r, `wr_req_len` = beats-1.
  - All three held stable until `wr_req_ready`; then go to DATA with beat_cnt = beats.
- DATA:
  - `wr_data_valid = val_empty_n`.
  - `val_read = val_empty_n & wr_data_ready`, so a beat transfers iff a pop occurs in the same cycle.
  - `wr_data_last` = (beat_cnt == 1).
  - Each transfer decrements beat_cnt and remain_r. After the last beat, go to RESP.
  - FIFO empty mid-burst: `wr_data_valid` = 0 and the FSM stalls; no bubble beat is emitted.
- RESP:
  - `wr_resp_ready` = 1.
  - On `wr_resp_valid`, addr_r += beats*(DATA_WIDTH/8). Address arithmetic is modulo 2^ADDR_WIDTH; no 4 KB split.
  - Then go to REQ if remain_r != 0, else DONE.
- DONE: `done` = 1 for exactly one cycle, `busy` = 0 next cycle, then IDLE.
  - A token already waiting may be popped no earlier than the cycle after DONE, so there is 1 idle cycle between jobs.
- Data integrity: values leave in FIFO order. Exactly num_vertices pops per job. Values left over after a job belong to the next job.
- Outside DATA: `val_read` = 0. Outside IDLE: `start_read` = 0.
- Throughput: 1 beat/cycle inside a burst when FIFO and sink are never stalled. Per-burst overhead is ≥2 cycles (REQ, RESP).

Test Plan:
- Single short job: base 0x1000, n=5, FIFO preloaded 1..5, ready always 1 -> one request (addr 0x1000, len 4), beats 1..5 with last on beat 5, one response, done pulse, exactly 1 token and 5 values popped.
- Multi-burst: base 0x2000, n=40, BURST_LEN=16 -> requests at 0x2000/len 15, 0x2040/len 15, 0x2080/len 7, in that order; 40 beats in order; done only after the 3rd response.
- Zero count: token with n=0 -> token popped, no request, no val_read, done asserted within 2 cycles.
- Backpressure: random wr_req_ready, wr_data_ready and val_empty_n gaps (~30%), n=33 -> request fields stable while waiting, no beat without a pop, all 33 values delivered in order, 3 bursts.
- Back-to-back tokens: 2 tokens queued (n=3 at 0x0, n=2 at 0x100) -> two independent jobs, two done pulses, second token popped only after the first done.
- Reset mid-burst: assert reset after beat 2 of 5 -> next cycle all outputs 0 and state IDLE; a new token with n=1 then runs to a normal done.
